ifu_prefetch: RTL

- Next-generation instruction fetch front end: AXI read master with up to MAX_OUTST requests in flight, feeding an in-order instruction queue of QDEPTH entries.
- Adds PC redirect with flush and discard of stale in-flight responses, plus fetch-error tagging.
- Sits between the core's AXI instruction port and the decode stage; decode consumes instructions through a valid/ready interface.

---
 rtl/axi_defs.sv | 40 ++++
 rtl/ifu_inst_fifo.sv | 77 +++++++
 rtl/ifu_prefetch.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/axi_defs.sv
`default_nettype none
// ============================================================================
//  Module   : axi_defs (package)
//  Purpose  : Shared AXI encodings and width constants for the instruction
//             fetch front end.
//  Contents : burst / response / protection encodings, channel field widths,
//             helper to derive ARSIZE from a byte count.
//  Revision : 1.0  initial release
// ============================================================================
package axi_defs;

  localparam int AXI_LEN_W   = 8;
  localparam int AXI_SIZE_W  = 3;
  localparam int AXI_BURST_W = 2;
  localparam int AXI_RESP_W  = 2;
  localparam int AXI_PROT_W  = 3;

  localparam logic [AXI_BURST_W-1:0] BURST_INCR = 2'b01;
  localparam logic [AXI_PROT_W-1:0]  PROT_INST  = 3'b100;
  localparam logic [AXI_LEN_W-1:0]   LEN_SINGLE = 8'd0;

  typedef enum logic [AXI_RESP_W-1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  // ARSIZE encoding for a transfer of 'bytes' bytes (log2).
  function automatic logic [AXI_SIZE_W-1:0] axi_size(input int bytes);
    logic [AXI_SIZE_W-1:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      if ((1 << i) == bytes) s = AXI_SIZE_W'(i);
    end
    return s;
  endfunction

endpackage : axi_defs
`default_nettype wire

// File: rtl/ifu_inst_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : ifu_inst_fifo
//  Purpose  : Synchronous FIFO holding fetched instruction entries.
//  Ports    : clk, rst      - clock, asynchronous active-high reset
//             push, din     - write an entry
//             pop           - remove the head entry
//             flush         - discard all entries (wins over push/pop)
//             dout          - head entry (driven from storage registers)
//             full, empty   - registered status flags
//             count         - registered occupancy
//  Revision : 1.0  initial release
// ============================================================================
module ifu_inst_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [CNT_W-1:0] count_nxt;

  always_comb begin
    do_pop    = pop && !empty;
    // A full FIFO may still take a write when the head leaves in the same cycle.
    do_push   = push && (!full || do_pop);
    count_nxt = count + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
      full  <= (count_nxt == CNT_W'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  // Storage needs no reset: it is only observed behind the empty flag.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule : ifu_inst_fifo
`default_nettype wire

// File: rtl/ifu_prefetch.sv
`default_nettype none
// ============================================================================
//  Module   : ifu_prefetch
//  Purpose  : Instruction prefetcher. Issues single-beat AXI reads with up to
//             MAX_OUTST in flight and queues returned instructions for decode.
//             Supports PC redirect with flush and discard of stale responses.
//  Ports    : clk, rst                 - clock, asynchronous active-high reset
//             enable                   - permit new AR issue
//             redirect_valid/_pc       - one-cycle PC redirect
//             axi_mst_ar*              - AXI read address channel (master)
//             axi_mst_r*               - AXI read data channel (master)
//             inst_valid/ready         - decode handshake
//             inst_pc, inst, inst_err  - head entry
//  Revision : 1.0  initial release
// ============================================================================
module ifu_prefetch
  import axi_defs::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                ID_W      = 4,
  parameter int                ARID_VAL  = 0,
  parameter int                QDEPTH    = 4,
  parameter int                MAX_OUTST = 2,
  parameter logic [ADDR_W-1:0] RESET_PC  = 32'h8000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   redirect_valid,
  input  logic [ADDR_W-1:0]      redirect_pc,
  output logic                   axi_mst_arvalid,
  input  logic                   axi_mst_arready,
  output logic [ID_W-1:0]        axi_mst_arid,
  output logic [ADDR_W-1:0]      axi_mst_araddr,
  output logic [AXI_LEN_W-1:0]   axi_mst_arlen,
  output logic [AXI_SIZE_W-1:0]  axi_mst_arsize,
  output logic [AXI_BURST_W-1:0] axi_mst_arburst,
  output logic [AXI_PROT_W-1:0]  axi_mst_arprot,
  input  logic                   axi_mst_rvalid,
  output logic                   axi_mst_rready,
  input  logic [DATA_W-1:0]      axi_mst_rdata,
  input  logic [AXI_RESP_W-1:0]  axi_mst_rresp,
  input  logic                   axi_mst_rlast,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic [ADDR_W-1:0]      inst_pc,
  output logic [DATA_W-1:0]      inst,
  output logic                   inst_err
);

  localparam int CNT_W = $clog2(QDEPTH + 1);
  localparam int SUM_W = CNT_W + 2;
  localparam int ENT_W = ADDR_W + DATA_W + 1;
  localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(DATA_W / 8);

  logic              arvalid_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] fetch_pc_nxt;
  logic [ADDR_W-1:0] ret_pc;
  logic [CNT_W-1:0]  outst;
  logic [CNT_W-1:0]  outst_nxt;
  logic [CNT_W-1:0]  drop;
  logic [CNT_W-1:0]  drop_nxt;
  logic              stale;
  logic              rready_q;
  logic              ar_hs;
  logic              r_hs;
  logic              keep;
  logic              issue;
  logic [SUM_W-1:0]  reserved;
  logic [CNT_W-1:0]  qcount;
  logic              q_full;
  logic              q_empty;
  logic [ENT_W-1:0]  q_din;
  logic [ENT_W-1:0]  q_dout;

  always_comb begin
    ar_hs = arvalid_q && axi_mst_arready;
    r_hs  = axi_mst_rvalid && rready_q;
    // Beats still owed to a pre-redirect stream, or arriving in the redirect
    // cycle itself, never reach the queue.
    keep  = r_hs && (drop == '0) && !redirect_valid;

    outst_nxt = outst + CNT_W'(ar_hs) - CNT_W'(r_hs);

    if (redirect_valid) begin
      // Everything still outstanding after this cycle belongs to the old path.
      drop_nxt = outst_nxt;
    end else begin
      drop_nxt = drop - CNT_W'(r_hs && (drop != '0)) + CNT_W'(ar_hs && stale);
    end

    // A stale AR finishing its handshake does not consume a fetch address
    // on the new path.
    if (redirect_valid)       fetch_pc_nxt = redirect_pc;
    else if (ar_hs && !stale) fetch_pc_nxt = fetch_pc + PC_INC;
    else                      fetch_pc_nxt = fetch_pc;

    // Slots already promised: live reads in flight, the AR completing now,
    // and queued entries. Using pre-update counts keeps this conservative.
    reserved = SUM_W'(outst - drop) + SUM_W'(ar_hs) + SUM_W'(qcount);

    issue = enable && (!arvalid_q || axi_mst_arready)
            && (reserved < SUM_W'(QDEPTH))
            && ((SUM_W'(outst) + SUM_W'(ar_hs)) < SUM_W'(MAX_OUTST));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arvalid_q <= 1'b0;
      araddr_q  <= RESET_PC;
      fetch_pc  <= RESET_PC;
      ret_pc    <= RESET_PC;
      outst     <= '0;
      drop      <= '0;
      stale     <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      rready_q <= 1'b1;
      fetch_pc <= fetch_pc_nxt;
      outst    <= outst_nxt;
      drop     <= drop_nxt;

      if (issue) begin
        arvalid_q <= 1'b1;
        araddr_q  <= fetch_pc_nxt;
      end else if (ar_hs) begin
        arvalid_q <= 1'b0;
      end

      // An AR caught mid-handshake by a redirect must still complete; mark it
      // so its beat is counted into drop once accepted.
      if (redirect_valid && arvalid_q && !axi_mst_arready) stale <= 1'b1;
      else if (ar_hs)                                      stale <= 1'b0;

      if (redirect_valid) ret_pc <= redirect_pc;
      else if (keep)      ret_pc <= ret_pc + PC_INC;
    end
  end

  assign q_din = {ret_pc, axi_mst_rdata, axi_mst_rresp[1]};

  ifu_inst_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (keep),
    .din   (q_din),
    .pop   (inst_valid && inst_ready),
    .flush (redirect_valid),
    .dout  (q_dout),
    .full  (q_full),
    .empty (q_empty),
    .count (qcount)
  );

  assign inst_valid = !q_empty;
  assign inst_pc    = q_dout[ENT_W-1 -: ADDR_W];
  assign inst       = q_dout[DATA_W:1];
  assign inst_err   = q_dout[0];

  assign axi_mst_arvalid = arvalid_q;
  assign axi_mst_araddr  = araddr_q;
  assign axi_mst_arid    = ID_W'(ARID_VAL);
  assign axi_mst_arlen   = LEN_SINGLE;
  assign axi_mst_arsize  = axi_size(DATA_W / 8);
  assign axi_mst_arburst = BURST_INCR;
  assign axi_mst_arprot  = PROT_INST;
  assign axi_mst_rready  = rready_q;

  // rlast is implied by single-beat reads; only rresp[1] marks a fault.
  logic unused_sigs;
  assign unused_sigs = &{1'b0, axi_mst_rlast, axi_mst_rresp[0], q_full};

endmodule : ifu_prefetch
`default_nettype wire
